stack_engine: RTL and testbench

STACK_ENGINE -- requirements
Module: stack_engine

---
 rtl/stack_engine.sv | 147 ++++++++++++++
 tb/tb_stack_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_engine.sv
// Downward-growing LIFO with a single registered response slot.
// Tracks fill level, a derived stack pointer and sticky overflow/underflow flags.
module stack_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  input  logic [1:0]               CMD_OP,
  input  logic [DATA_WIDTH-1:0]    CMD_DATA,
  output logic                     CMD_READY,
  output logic                     RSP_VALID,
  output logic [DATA_WIDTH-1:0]    RSP_DATA,
  output logic                     RSP_ERR,
  input  logic                     RSP_READY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [ADDR_WIDTH-1:0]    SP,
  output logic                     ERR_OVF,
  output logic                     ERR_UNF,
  input  logic                     ERR_CLR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] OpNop     = 2'b00;
  localparam logic [1:0] OpPush    = 2'b01;
  localparam logic [1:0] OpPop     = 2'b10;
  localparam logic [1:0] OpReplace = 2'b11;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]         count_q, count_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_unf_q, err_unf_d;

  logic                  accept;
  logic                  is_empty, is_full;
  logic [AW-1:0]         top_idx;
  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ovf_set, unf_set;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CW'(DEPTH));
  assign top_idx   = AW'(count_q - CW'(1));

  // The response slot frees up on the same edge it is consumed, so a new
  // command can land while the old response is being taken.
  assign CMD_READY = RST & (~rsp_valid_q | RSP_READY);
  assign accept    = CMD_VALID & CMD_READY & (CMD_OP != OpNop);

  always_comb begin
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q & ~RSP_READY;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    wr_en       = 1'b0;
    wr_idx      = count_q[AW-1:0];
    wr_data     = CMD_DATA;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;

    if (accept) begin
      unique case (CMD_OP)
        OpPush: begin
          if (is_full) begin
            ovf_set = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = count_q[AW-1:0];
            count_d = count_q + CW'(1);
          end
        end
        OpPop, OpReplace: begin
          rsp_valid_d = 1'b1;
          if (is_empty) begin
            unf_set    = 1'b1;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            // Read happens before the write lands, so REPLACE returns the old top.
            rsp_data_d = mem[top_idx];
            rsp_err_d  = 1'b0;
            if (CMD_OP == OpReplace) begin
              wr_en  = 1'b1;
              wr_idx = top_idx;
            end else begin
              count_d = count_q - CW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Set wins over clear when both hit on the same edge.
    err_ovf_d = (err_ovf_q & ~ERR_CLR) | ovf_set;
    err_unf_d = (err_unf_q & ~ERR_CLR) | unf_set;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign COUNT     = count_q;
  assign EMPTY     = is_empty;
  assign FULL      = is_full;
  assign SP        = BASE_ADDR - ADDR_WIDTH'(count_q);
  assign ERR_OVF   = err_ovf_q;
  assign ERR_UNF   = err_unf_q;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: directed vector table, hand-written corner sequences,
// then random traffic checked against a queue-based model of the stack.
module tb_stack_engine;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 26;
  localparam logic [AW-1:0] BASE = 26'h3FFFFFF;

  logic          CLK;
  logic          RST;
  logic          CMD_VALID;
  logic [1:0]    CMD_OP;
  logic [DW-1:0] CMD_DATA;
  logic          CMD_READY;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_DATA;
  logic          RSP_ERR;
  logic          RSP_READY;
  logic [2:0]    COUNT;
  logic          EMPTY;
  logic          FULL;
  logic [AW-1:0] SP;
  logic          ERR_OVF;
  logic          ERR_UNF;
  logic          ERR_CLR;

  stack_engine #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CMD_VALID(CMD_VALID),
    .CMD_OP   (CMD_OP),
    .CMD_DATA (CMD_DATA),
    .CMD_READY(CMD_READY),
    .RSP_VALID(RSP_VALID),
    .RSP_DATA (RSP_DATA),
    .RSP_ERR  (RSP_ERR),
    .RSP_READY(RSP_READY),
    .COUNT    (COUNT),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .SP       (SP),
    .ERR_OVF  (ERR_OVF),
    .ERR_UNF  (ERR_UNF),
    .ERR_CLR  (ERR_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the stack is a queue, the response slot is a few variables.
  logic [DW-1:0] m_q[$];
  logic          m_rv, m_re, m_ovf, m_unf, m_ready;
  logic [DW-1:0] m_rd;

  task automatic cyc(input logic rst, input logic v, input logic [1:0] op,
                     input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic so, su;
    logic [AW-1:0] exp_sp;
    RST = rst; CMD_VALID = v; CMD_OP = op; CMD_DATA = d; RSP_READY = rdy; ERR_CLR = clr;
    #1;
    m_ready = rst && (!m_rv || rdy);
    chk("cmd_ready", {63'd0, CMD_READY}, {63'd0, m_ready});
    @(posedge CLK);
    if (!rst) begin
      m_q.delete();
      m_rv = 0; m_rd = '0; m_re = 0; m_ovf = 0; m_unf = 0;
    end else begin
      so = 0; su = 0;
      if (rdy) m_rv = 0;
      if (v && m_ready && op != 2'b00) begin
        if (op == 2'b01) begin
          if (m_q.size() == DEPTH) so = 1;
          else m_q.push_back(d);
        end else begin
          m_rv = 1;
          if (m_q.size() == 0) begin
            su = 1; m_rd = '0; m_re = 1;
          end else begin
            m_rd = m_q.pop_back();
            m_re = 0;
            if (op == 2'b11) m_q.push_back(d);
          end
        end
      end
      m_ovf = (m_ovf && !clr) || so;
      m_unf = (m_unf && !clr) || su;
    end
    #1;
    exp_sp = BASE - AW'(m_q.size());
    chk("count", 64'(COUNT), 64'(m_q.size()));
    chk("empty", {63'd0, EMPTY}, {63'd0, m_q.size() == 0});
    chk("full", {63'd0, FULL}, {63'd0, m_q.size() == DEPTH});
    chk("sp", 64'(SP), 64'(exp_sp));
    chk("rsp_valid", {63'd0, RSP_VALID}, {63'd0, m_rv});
    if (m_rv) begin
      chk("rsp_data", 64'(RSP_DATA), 64'(m_rd));
      chk("rsp_err", {63'd0, RSP_ERR}, {63'd0, m_re});
    end
    chk("err_ovf", {63'd0, ERR_OVF}, {63'd0, m_ovf});
    chk("err_unf", {63'd0, ERR_UNF}, {63'd0, m_unf});
  endtask

  typedef struct {
    logic          rst;
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic          rdy;
    logic          clr;
    int            e_cnt;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_re;
    logic          e_ovf;
    logic          e_unf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [1:0] op, input logic [DW-1:0] data,
                     input logic rdy, input logic clr, input int e_cnt, input logic e_rv,
                     input logic [DW-1:0] e_rd, input logic e_re, input logic e_ovf,
                     input logic e_unf);
    vec_t t;
    t.rst = rst; t.op = op; t.data = data; t.rdy = rdy; t.clr = clr;
    t.e_cnt = e_cnt; t.e_rv = e_rv; t.e_rd = e_rd; t.e_re = e_re;
    t.e_ovf = e_ovf; t.e_unf = e_unf;
    tbl.push_back(t);
  endtask

  initial begin
    logic [AW-1:0] tsp;
    RST = 0; CMD_VALID = 0; CMD_OP = 0; CMD_DATA = 0; RSP_READY = 0; ERR_CLR = 0;
    m_rv = 0; m_rd = '0; m_re = 0; m_ovf = 0; m_unf = 0; m_ready = 0;

    // rst op data rdy clr | cnt rv rd re ovf unf
    add(0, 0, 0,     1, 0,  0, 0, 0,     0, 0, 0);
    add(1, 1, 'hA,   1, 0,  1, 0, 0,     0, 0, 0);
    add(1, 1, 'hB,   1, 0,  2, 0, 0,     0, 0, 0);
    add(1, 1, 'hC,   1, 0,  3, 0, 0,     0, 0, 0);
    add(1, 2, 0,     1, 0,  2, 1, 'hC,   0, 0, 0);
    add(1, 2, 0,     1, 0,  1, 1, 'hB,   0, 0, 0);
    add(1, 2, 0,     1, 0,  0, 1, 'hA,   0, 0, 0);
    add(1, 0, 0,     1, 0,  0, 0, 0,     0, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 1, DW'(i), 1, 0, i, 0, 0, 0, 0, 0);
    add(1, 1, 5,     1, 0,  4, 0, 0,     0, 1, 0);
    add(1, 2, 0,     1, 0,  3, 1, 4,     0, 1, 0);
    add(1, 2, 0,     1, 0,  2, 1, 3,     0, 1, 0);
    add(1, 2, 0,     1, 0,  1, 1, 2,     0, 1, 0);
    add(1, 2, 0,     1, 0,  0, 1, 1,     0, 1, 0);
    add(1, 2, 0,     1, 0,  0, 1, 0,     1, 1, 1);
    add(1, 3, 'h55,  1, 0,  0, 1, 0,     1, 1, 1);
    add(1, 0, 0,     1, 1,  0, 0, 0,     0, 0, 0);
    add(1, 1, 'h11,  1, 0,  1, 0, 0,     0, 0, 0);
    add(1, 1, 'h22,  1, 0,  2, 0, 0,     0, 0, 0);
    add(1, 3, 'h33,  1, 0,  2, 1, 'h22,  0, 0, 0);
    add(1, 2, 0,     1, 0,  1, 1, 'h33,  0, 0, 0);
    add(1, 2, 0,     1, 0,  0, 1, 'h11,  0, 0, 0);
    add(1, 0, 0,     1, 0,  0, 0, 0,     0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, 1'b1, tbl[i].op, tbl[i].data, tbl[i].rdy, tbl[i].clr);
      tsp = BASE - AW'(tbl[i].e_cnt);
      chk($sformatf("tbl%0d_count", i), 64'(COUNT), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_sp", i), 64'(SP), 64'(tsp));
      chk($sformatf("tbl%0d_rv", i), {63'd0, RSP_VALID}, {63'd0, tbl[i].e_rv});
      if (tbl[i].e_rv || !tbl[i].rst) begin
        chk($sformatf("tbl%0d_rd", i), 64'(RSP_DATA), 64'(tbl[i].e_rd));
        chk($sformatf("tbl%0d_re", i), {63'd0, RSP_ERR}, {63'd0, tbl[i].e_re});
      end
      chk($sformatf("tbl%0d_ovf", i), {63'd0, ERR_OVF}, {63'd0, tbl[i].e_ovf});
      chk($sformatf("tbl%0d_unf", i), {63'd0, ERR_UNF}, {63'd0, tbl[i].e_unf});
    end

    // Backpressure: response must hold while the consumer stalls.
    cyc(1, 1, 1, 'h7, 1, 0);
    cyc(1, 1, 1, 'h8, 1, 0);
    cyc(1, 1, 2, 0, 0, 0);
    chk("bp_first_rv", {63'd0, RSP_VALID}, 64'd1);
    chk("bp_first_rd", 64'(RSP_DATA), 64'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 2, 0, 0, 0);
      chk("bp_hold_ready", {63'd0, CMD_READY}, 64'd0);
      chk("bp_hold_rv", {63'd0, RSP_VALID}, 64'd1);
      chk("bp_hold_rd", 64'(RSP_DATA), 64'h8);
      chk("bp_hold_count", 64'(COUNT), 64'd1);
    end
    cyc(1, 1, 2, 0, 1, 0);
    chk("bp_next_rv", {63'd0, RSP_VALID}, 64'd1);
    chk("bp_next_rd", 64'(RSP_DATA), 64'h7);
    chk("bp_next_count", 64'(COUNT), 64'd0);
    cyc(1, 1, 0, 0, 1, 0);
    chk("bp_drain_rv", {63'd0, RSP_VALID}, 64'd0);

    // Reset mid-operation with a pending response.
    cyc(1, 1, 1, 'h1, 1, 0);
    cyc(1, 1, 1, 'h2, 1, 0);
    cyc(1, 1, 1, 'h3, 1, 0);
    cyc(1, 1, 2, 0, 0, 0);
    chk("rst_pre_rv", {63'd0, RSP_VALID}, 64'd1);
    chk("rst_pre_count", 64'(COUNT), 64'd2);
    cyc(0, 1, 2, 0, 1, 0);
    chk("rst_ready", {63'd0, CMD_READY}, 64'd0);
    chk("rst_rv", {63'd0, RSP_VALID}, 64'd0);
    chk("rst_count", 64'(COUNT), 64'd0);
    chk("rst_sp", 64'(SP), 64'(BASE));
    cyc(1, 1, 0, 0, 1, 0);

    // Set wins over a simultaneous clear.
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, DW'(i + 'h40), 1, 0);
    cyc(1, 1, 1, 'h99, 1, 1);
    chk("setwin_ovf", {63'd0, ERR_OVF}, 64'd1);
    cyc(1, 1, 0, 0, 1, 1);
    chk("clr_ovf", {63'd0, ERR_OVF}, 64'd0);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1,
          ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
          2'($urandom_range(0, 3)),
          $urandom,
          ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
          ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
